// File: rtl/uart_pkg.sv
// Shared constants, state encodings and framing helpers for the UART command slave.
package uart_pkg;

    localparam int unsigned BR_DEFAULT = 434;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned RW_BIT     = 7;

    localparam int unsigned CNT_W = 9;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned PER_W = 5;

    typedef enum logic [3:0] {
        WAIT_HDR,
        WAIT_DATA,
        WR_STROBE,
        RD_REQ,
        RD_CAP,
        TURN,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_BITS
    } rx_state_t;

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/uart_cmd_slave_rx.sv
// Byte receiver: synchronizer, start validation, mid-bit sampling, parity/stop check.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int unsigned BR = BR_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       rx,
    output logic       byte_vld,
    output logic [7:0] byte_data,
    output logic       byte_err,
    output logic       rx_active_c
);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BR / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BR - 1);
    localparam logic [IDX_W-1:0] PAR_IDX   = IDX_W'(DATA_BITS);

    logic             rx_s1;
    logic             rx_s2;
    logic             rx_prev;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [7:0]       shreg;
    logic             par_bit;

    assign rx_active_c = (state != RX_IDLE);

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Start validation at half a bit, then sample data, parity and stop at mid-bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RX_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            byte_vld  <= 1'b0;
            byte_data <= '0;
            byte_err  <= 1'b0;
        end else begin
            byte_vld <= 1'b0;
            byte_err <= 1'b0;
            if (!enable) begin
                state <= RX_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    RX_IDLE: begin
                        if (rx_prev && !rx_s2) begin
                            state <= RX_START;
                            cnt   <= '0;
                        end
                    end
                    RX_START: begin
                        if (cnt == HALF_LAST) begin
                            cnt   <= '0;
                            idx   <= '0;
                            state <= rx_s2 ? RX_IDLE : RX_BITS;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    RX_BITS: begin
                        if (cnt == BIT_LAST) begin
                            cnt <= '0;
                            idx <= idx + IDX_W'(1);
                            if (idx < PAR_IDX) begin
                                shreg <= {rx_s2, shreg[7:1]};
                            end else if (idx == PAR_IDX) begin
                                par_bit <= rx_s2;
                            end else begin
                                state <= RX_IDLE;
                                if (rx_s2 && (par_bit == odd_parity(shreg))) begin
                                    byte_vld  <= 1'b1;
                                    byte_data <= shreg;
                                end else begin
                                    byte_err <= 1'b1;
                                end
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_cmd_slave.sv
// UART register-access responder: decodes write/read commands and answers reads on tx.
module uart_cmd_slave
    import uart_pkg::*;
#(
    parameter int unsigned BR         = BR_DEFAULT,
    parameter int unsigned TURNAROUND = 2,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       tx,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       frame_err
);

    localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(BR - 1);
    localparam logic [PER_W-1:0] TURN_LAST    = PER_W'(TURNAROUND - 1);
    localparam logic [PER_W-1:0] TIMEOUT_LAST = PER_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST    = IDX_W'(DATA_BITS - 1);

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [IDX_W-1:0] bit_idx;
    logic [PER_W-1:0] per_cnt;
    logic [7:0]       tx_shreg;
    logic             tx_par;

    logic             rx_enable_c;
    logic             byte_vld;
    logic [7:0]       byte_data;
    logic             byte_err;
    logic             rx_active_c;

    // Receiver listens only while no read response is in flight (half duplex).
    assign rx_enable_c = (state == WAIT_HDR) || (state == WAIT_DATA) || (state == WR_STROBE);

    uart_byte_rx #(
        .BR (BR)
    ) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (rx_enable_c),
        .rx          (rx),
        .byte_vld    (byte_vld),
        .byte_data   (byte_data),
        .byte_err    (byte_err),
        .rx_active_c (rx_active_c)
    );

    // Command FSM with the transmit shifter and the turnaround/timeout counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= WAIT_HDR;
            tx        <= 1'b1;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            per_cnt   <= '0;
            tx_shreg  <= '0;
            tx_par    <= 1'b0;
        end else begin
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                WAIT_HDR: begin
                    bit_cnt <= '0;
                    per_cnt <= '0;
                    if (byte_vld) begin
                        reg_addr  <= byte_data[6:0];
                        busy      <= 1'b1;
                        reg_rd_en <= !byte_data[RW_BIT];
                        state     <= byte_data[RW_BIT] ? WAIT_DATA : RD_REQ;
                    end else if (byte_err) begin
                        frame_err <= 1'b1;
                    end
                end
                WAIT_DATA: begin
                    if (byte_vld) begin
                        reg_wdata <= byte_data;
                        reg_wr_en <= 1'b1;
                        state     <= WR_STROBE;
                    end else if (byte_err) begin
                        frame_err <= 1'b1;
                        busy      <= 1'b0;
                        state     <= WAIT_HDR;
                    end else if (!rx_active_c) begin
                        // Timeout clock pauses while a byte is being received.
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (per_cnt == TIMEOUT_LAST) begin
                                frame_err <= 1'b1;
                                busy      <= 1'b0;
                                state     <= WAIT_HDR;
                            end else begin
                                per_cnt <= per_cnt + PER_W'(1);
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                WR_STROBE: begin
                    busy  <= 1'b0;
                    state <= WAIT_HDR;
                end
                RD_REQ: begin
                    state <= RD_CAP;
                end
                RD_CAP: begin
                    tx_shreg <= reg_rdata;
                    tx_par   <= odd_parity(reg_rdata);
                    bit_cnt  <= '0;
                    per_cnt  <= '0;
                    state    <= TURN;
                end
                TURN: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (per_cnt == TURN_LAST) begin
                            tx    <= 1'b0;
                            state <= TX_START;
                        end else begin
                            per_cnt <= per_cnt + PER_W'(1);
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                TX_START: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt  <= '0;
                        bit_idx  <= '0;
                        tx       <= tx_shreg[0];
                        tx_shreg <= {1'b0, tx_shreg[7:1]};
                        state    <= TX_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (bit_idx == DATA_LAST) begin
                            tx    <= tx_par;
                            state <= TX_PARITY;
                        end else begin
                            tx       <= tx_shreg[0];
                            tx_shreg <= {1'b0, tx_shreg[7:1]};
                            bit_idx  <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                TX_PARITY: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        tx      <= 1'b1;
                        state   <= TX_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= WAIT_HDR;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: state <= WAIT_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_slave.sv
// Scoreboard bench for uart_cmd_slave: transaction-level model feeds an expectation queue.
module tb_uart_cmd_slave;

    localparam int unsigned BR         = 48;
    localparam int unsigned TURNAROUND = 2;
    localparam int unsigned TIMEOUT    = 16;

    typedef enum logic [1:0] {EV_WR, EV_RD, EV_TX, EV_ERR} ev_kind_t;
    typedef struct packed {
        ev_kind_t   kind;
        logic [6:0] addr;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       tx;
    logic       reg_wr_en;
    logic       reg_rd_en;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_rd_cyc = 0;
    int rst_epoch = 0;

    ev_t exp_q[$];

    // Model state: pending write header and the register contents it believes in.
    bit         m_pending = 1'b0;
    logic [6:0] m_addr = '0;
    logic [7:0] m_mem[128];
    logic [7:0] mem_salt = '0;

    // Register file seen by the DUT.
    bit         wr_seen[128];
    logic [7:0] tb_mem[128];

    uart_cmd_slave #(
        .BR         (BR),
        .TURNAROUND (TURNAROUND),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .tx        (tx),
        .reg_wr_en (reg_wr_en),
        .reg_rd_en (reg_rd_en),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_val(input logic [6:0] a);
        return 8'({1'b0, a} * 8'd73) ^ mem_salt;
    endfunction

    // External register file: read data valid the cycle after reg_rd_en.
    always @(posedge clk) begin
        if (reg_wr_en) begin
            tb_mem[reg_addr]  <= reg_wdata;
            wr_seen[reg_addr] <= 1'b1;
        end
        if (reg_rd_en) reg_rdata <= wr_seen[reg_addr] ? tb_mem[reg_addr] : init_val(reg_addr);
    end

    function automatic ev_t mk_ev(input ev_kind_t k, input logic [6:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic observe(input ev_t got);
        ev_t want;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind=%0d addr=0x%0h data=0x%0h expected none (t=%0t)",
                     got.kind, got.addr, got.data, $time);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                n_bad++;
                $display("FAIL scoreboard: got kind=%0d addr=0x%0h data=0x%0h expected kind=%0d addr=0x%0h data=0x%0h (t=%0t)",
                         got.kind, got.addr, got.data, want.kind, want.addr, want.data, $time);
            end
        end
    endtask

    // Strobe monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_wr_en) observe(mk_ev(EV_WR, reg_addr, reg_wdata));
            if (reg_rd_en) begin
                observe(mk_ev(EV_RD, reg_addr, 8'h00));
                last_rd_cyc = cyc;
            end
            if (frame_err) observe(mk_ev(EV_ERR, 7'h00, 8'h00));
        end
    end

    // Serial response monitor: every cycle of the frame is sampled to check bit hold times.
    initial begin : tx_mon
        logic        prv;
        logic [10:0] bits;
        bit          steady;
        int          ep;
        int          lat;
        prv = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && prv && !tx) begin
                ep      = rst_epoch;
                lat     = cyc - last_rd_cyc;
                bits    = '1;
                bits[0] = tx;
                steady  = 1'b1;
                for (int k = 1; k < int'(11 * BR); k++) begin
                    @(negedge clk);
                    if (k % BR == 0) bits[k / BR] = tx;
                    else if (tx !== bits[k / BR]) steady = 1'b0;
                end
                if (ep == rst_epoch) begin
                    chk("tx_latency", lat, TURNAROUND * BR + 2);
                    chk("tx_framing", {29'd0, steady, bits[9] == ~^bits[8:1], bits[10]}, 32'd7);
                    observe(mk_ev(EV_TX, 7'h00, bits[8:1]));
                end
            end
            prv = tx;
        end
    end

    // Protocol-level model: what a byte does given the transaction in progress.
    task automatic model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            exp_q.push_back(mk_ev(EV_ERR, 7'h00, 8'h00));
            m_pending = 1'b0;
        end else if (m_pending) begin
            exp_q.push_back(mk_ev(EV_WR, m_addr, b));
            m_mem[m_addr] = b;
            m_pending = 1'b0;
        end else if (b[7]) begin
            m_pending = 1'b1;
            m_addr = b[6:0];
        end else begin
            exp_q.push_back(mk_ev(EV_RD, b[6:0], 8'h00));
            exp_q.push_back(mk_ev(EV_TX, 7'h00, m_mem[b[6:0]]));
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit modeled);
        logic [10:0] fr;
        if (modeled) model_byte(b, !(bad_par || bad_stop));
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx = fr[i];
            repeat (BR) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < int'(20 * BR)) begin
            @(negedge clk);
            n++;
        end
        chk(name, busy, 0);
        repeat (2 * BR) @(negedge clk);
    endtask

    task automatic write_pair(input logic [6:0] a, input logic [7:0] d, input int gap_bits);
        send_byte({1'b1, a}, 1'b0, 1'b0, 1'b1);
        repeat (gap_bits * BR) @(negedge clk);
        send_byte(d, 1'b0, 1'b0, 1'b1);
        wait_idle("idle_after_write");
    endtask

    task automatic read_reg(input logic [6:0] a);
        send_byte({1'b0, a}, 1'b0, 1'b0, 1'b1);
        wait_idle("idle_after_read");
    endtask

    initial begin : stim
        int target;
        int op;
        logic [6:0] a;
        logic [7:0] d;
        bit bp;

        mem_salt = 8'($urandom);
        for (int i = 0; i < 128; i++) m_mem[i] = init_val(7'(i));

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", reg_wr_en, 0);
        chk("rst_rd_en", reg_rd_en, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_addr", reg_addr, 0);
        chk("rst_wdata", reg_wdata, 0);
        rst_n = 1'b1;
        repeat (2 * BR) @(negedge clk);

        // Basic write, then read back a known pattern
        write_pair(7'h05, 8'h3C, 1);
        write_pair(7'h12, 8'hA7, 0);
        read_reg(7'h12);

        // Bad header parity drops the byte; the following 0x3C is then a read header
        send_byte(8'h85, 1'b1, 1'b0, 1'b1);
        repeat (BR) @(negedge clk);
        send_byte(8'h3C, 1'b0, 1'b0, 1'b1);
        wait_idle("idle_after_err_read");
        write_pair(7'h05, 8'h3C, 0);

        // Short glitch is a false start
        rx = 1'b0;
        repeat (BR / 4) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BR) @(negedge clk);
        chk("glitch_busy", busy, 0);

        // Write header followed by silence times out
        send_byte(8'h85, 1'b0, 1'b0, 1'b1);
        chk("timeout_busy_hi", busy, 1);
        exp_q.push_back(mk_ev(EV_ERR, 7'h00, 8'h00));
        m_pending = 1'b0;
        repeat ((TIMEOUT + 2) * BR) @(negedge clk);
        chk("timeout_busy_lo", busy, 0);
        repeat (BR) @(negedge clk);

        // Reset in the middle of data bit 3 of a response
        send_byte(8'h05, 1'b0, 1'b0, 1'b1);
        target = last_rd_cyc + 2 + int'(TURNAROUND * BR) + int'(4 * BR) + int'(BR / 2);
        while (cyc < target) @(negedge clk);
        chk("mid_tx_busy", busy, 1);
        chk("mid_tx_bit3", tx, 32'(m_mem[5][3]));
        rst_n = 1'b0;
        rst_epoch++;
        exp_q.delete();
        m_pending = 1'b0;
        @(negedge clk);
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        chk("abort_wr_en", reg_wr_en, 0);
        chk("abort_rd_en", reg_rd_en, 0);
        chk("abort_frame_err", frame_err, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BR) @(negedge clk);
        read_reg(7'h05);

        // A byte arriving during the response is ignored
        send_byte(8'h12, 1'b0, 1'b0, 1'b1);
        send_byte(8'h85, 1'b0, 1'b0, 1'b0);
        wait_idle("idle_after_half_duplex");
        write_pair(7'h05, 8'h5A, 0);
        read_reg(7'h05);

        // Randomized traffic
        for (int it = 0; it < 24; it++) begin
            op = int'($urandom_range(0, 4));
            a  = 7'($urandom_range(0, 15));
            d  = 8'($urandom);
            bp = 1'($urandom_range(0, 1));
            case (op)
                0, 1: write_pair(a, d, int'($urandom_range(0, 4)));
                2: read_reg(a);
                3: begin
                    send_byte({1'b1, a}, 1'b0, 1'b0, 1'b1);
                    send_byte(d, bp, !bp, 1'b1);
                    wait_idle("idle_after_bad_data");
                end
                default: begin
                    send_byte(d, 1'b1, 1'b0, 1'b1);
                    wait_idle("idle_after_bad_hdr");
                end
            endcase
        end

        repeat (4 * BR) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Run-time bound
    initial begin : watchdog
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget, expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
